flag_register: RTL and testbench

- Holds the architectural NZCV condition flags between the ALU and the branch-condition evaluator.
- Takes ALU flag results under a per-flag write mask and drives the four registered flags straight to the condition evaluator.
- Has a small LIFO shadow stack. Flags are saved on interrupt/exception entry and restored on return, so nested handlers do not corrupt the interrupted code's conditions.

---
 rtl/flag_register_pkg.sv | 20 ++
 rtl/flag_shadow_stack.sv | 74 +++++++
 rtl/flag_register.sv | 71 +++++++
 tb/tb_flag_register.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/flag_register_pkg.sv
// Shared NZCV definitions used by the ALU, flag register and condition evaluator.
package flag_register_pkg;

  // Bit positions within an NZCV nibble.
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef logic [3:0] nzcv_t;

  localparam nzcv_t FLAG_WRITE_ALL  = 4'b1111;
  localparam nzcv_t FLAG_WRITE_NONE = 4'b0000;

  // Apply a per-flag write mask: masked-on bits take the new value.
  function automatic nzcv_t nzcv_merge(nzcv_t cur, nzcv_t upd, nzcv_t mask);
    return (cur & ~mask) | (upd & mask);
  endfunction

endpackage

// File: rtl/flag_shadow_stack.sv
// Saturating LIFO of NZCV snapshots with sticky overflow/underflow flags.
module flag_shadow_stack
  import flag_register_pkg::*;
#(
  parameter int unsigned Depth  = 4,
  parameter int unsigned DepthW = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              clear_error_i,
  input  nzcv_t             data_i,
  output nzcv_t             top_o,
  output logic              pop_ok_o,
  output logic [DepthW-1:0] depth_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam int unsigned IdxW = $clog2(Depth);

  nzcv_t             mem_q [Depth];
  logic [DepthW-1:0] depth_q, depth_d, depth_m1;
  logic [IdxW-1:0]   push_idx, top_idx;
  logic              push_ok, pop_ok, ovf_evt, unf_evt;
  logic              ovf_q, ovf_d, unf_q, unf_d;

  // Push/pop qualification; simultaneous push and pop cancel out entirely.
  always_comb begin
    full_o   = (depth_q == DepthW'(Depth));
    empty_o  = (depth_q == '0);
    push_ok  = push_i & ~pop_i & ~full_o;
    pop_ok   = pop_i & ~push_i & ~empty_o;
    ovf_evt  = push_i & ~pop_i & full_o;
    unf_evt  = pop_i & ~push_i & empty_o;
    depth_m1 = depth_q - DepthW'(1);
    push_idx = depth_q[IdxW-1:0];
    top_idx  = depth_m1[IdxW-1:0];
    depth_d  = depth_q;
    if (push_ok) depth_d = depth_q + DepthW'(1);
    else if (pop_ok) depth_d = depth_m1;
    // A new error event beats a concurrent clear.
    ovf_d = ovf_evt | (ovf_q & ~clear_error_i);
    unf_d = unf_evt | (unf_q & ~clear_error_i);
  end

  // Depth counter and sticky error flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Snapshot storage; contents are meaningless beyond depth so no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[push_idx] <= data_i;
  end

  assign top_o       = mem_q[top_idx];
  assign pop_ok_o    = pop_ok;
  assign depth_o     = depth_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;

endmodule

// File: rtl/flag_register.sv
// Architectural NZCV register with masked ALU update and a shadow stack for traps.
module flag_register
  import flag_register_pkg::*;
#(
  parameter int unsigned SAVE_DEPTH  = 4,
  parameter int unsigned DEPTH_WIDTH = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   alu_negative,
  input  logic                   alu_zero,
  input  logic                   alu_carry,
  input  logic                   alu_overflow,
  input  logic [3:0]             flag_write_mask,
  input  logic                   save,
  input  logic                   restore,
  input  logic                   clear_error,
  output logic                   negative_flag,
  output logic                   zero_flag,
  output logic                   carry_flag,
  output logic                   overflow_flag,
  output logic [DEPTH_WIDTH-1:0] stack_depth,
  output logic                   stack_overflow,
  output logic                   stack_underflow
);

  nzcv_t nzcv_q, nzcv_d, alu_nzcv, stack_top;
  logic  pop_ok;
  logic  unused_full, unused_empty;

  flag_shadow_stack #(
    .Depth  (SAVE_DEPTH),
    .DepthW (DEPTH_WIDTH)
  ) u_stack (
    .clk_i         (clock),
    .rst_ni        (reset),
    .push_i        (save),
    .pop_i         (restore),
    .clear_error_i (clear_error),
    .data_i        (nzcv_q),
    .top_o         (stack_top),
    .pop_ok_o      (pop_ok),
    .depth_o       (stack_depth),
    .full_o        (unused_full),
    .empty_o       (unused_empty),
    .overflow_o    (stack_overflow),
    .underflow_o   (stack_underflow)
  );

  // A successful restore overrides the ALU write for all four flags.
  always_comb begin
    alu_nzcv = '0;
    alu_nzcv[FLAG_N] = alu_negative;
    alu_nzcv[FLAG_Z] = alu_zero;
    alu_nzcv[FLAG_C] = alu_carry;
    alu_nzcv[FLAG_V] = alu_overflow;
    nzcv_d = pop_ok ? stack_top : nzcv_merge(nzcv_q, alu_nzcv, flag_write_mask);
  end

  // NZCV state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) nzcv_q <= '0;
    else        nzcv_q <= nzcv_d;
  end

  assign negative_flag = nzcv_q[FLAG_N];
  assign zero_flag     = nzcv_q[FLAG_Z];
  assign carry_flag    = nzcv_q[FLAG_C];
  assign overflow_flag = nzcv_q[FLAG_V];

endmodule

// File: tb/tb_flag_register.sv
// Scoreboard bench for flag_register: driver queues expectations, monitor checks after each edge.
module tb_flag_register;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       alu_negative = 1'b0, alu_zero = 1'b0, alu_carry = 1'b0, alu_overflow = 1'b0;
  logic [3:0] flag_write_mask = 4'b0;
  logic       save = 1'b0, restore = 1'b0, clear_error = 1'b0;
  logic       negative_flag, zero_flag, carry_flag, overflow_flag;
  logic [2:0] stack_depth;
  logic       stack_overflow, stack_underflow;

  // Observed tuple: {NZCV, depth, overflow, underflow}
  typedef struct {
    string      name;
    logic [8:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  flag_register #(
    .SAVE_DEPTH  (4),
    .DEPTH_WIDTH (3)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .alu_negative    (alu_negative),
    .alu_zero        (alu_zero),
    .alu_carry       (alu_carry),
    .alu_overflow    (alu_overflow),
    .flag_write_mask (flag_write_mask),
    .save            (save),
    .restore         (restore),
    .clear_error     (clear_error),
    .negative_flag   (negative_flag),
    .zero_flag       (zero_flag),
    .carry_flag      (carry_flag),
    .overflow_flag   (overflow_flag),
    .stack_depth     (stack_depth),
    .stack_overflow  (stack_overflow),
    .stack_underflow (stack_underflow)
  );

  always #5 clock = ~clock;

  function automatic logic [8:0] observed();
    return {negative_flag, zero_flag, carry_flag, overflow_flag, stack_depth,
            stack_overflow, stack_underflow};
  endfunction

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got nzcv=%b depth=%0d ovf=%b unf=%b, want nzcv=%b depth=%0d ovf=%b unf=%b",
               name, got[8:5], got[4:2], got[1], got[0], exp[8:5], exp[4:2], exp[1], exp[0]);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge and queue its expected result.
  task automatic step(input string name, input logic [3:0] alu, input logic [3:0] mask,
                      input logic sv, input logic rs, input logic clr,
                      input logic [3:0] e_nzcv, input logic [2:0] e_depth,
                      input logic e_ovf, input logic e_unf);
    exp_t e;
    @(negedge clock);
    {alu_negative, alu_zero, alu_carry, alu_overflow} = alu;
    flag_write_mask = mask;
    save = sv;
    restore = rs;
    clear_error = clr;
    e.name = name;
    e.val  = {e_nzcv, e_depth, e_ovf, e_unf};
    exp_q.push_back(e);
  endtask

  // Monitor: one expectation retires per clock edge.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.name, observed(), e.val);
      end
    end
  end

  task automatic drain();
    int budget = 10;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clock);
      budget--;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    check("reset_state", observed(), 9'b0000_000_0_0);
    @(negedge clock);
    reset = 1'b1;

    //    name            alu      mask     sv rs clr  nzcv     d     o  u
    step("hold_none",    4'b1111, 4'b0000, 0, 0, 0,  4'b0000, 3'd0, 0, 0);
    step("alu_all",      4'b1011, 4'b1111, 0, 0, 0,  4'b1011, 3'd0, 0, 0);
    step("masked_z",     4'b0100, 4'b0100, 0, 0, 0,  4'b1111, 3'd0, 0, 0);
    step("set_1010",     4'b1010, 4'b1111, 0, 0, 0,  4'b1010, 3'd0, 0, 0);
    step("save_write",   4'b0101, 4'b1111, 1, 0, 0,  4'b0101, 3'd1, 0, 0);
    step("restore_ovr",  4'b1111, 4'b1111, 0, 1, 0,  4'b1010, 3'd0, 0, 0);

    step("set_0001",     4'b0001, 4'b1111, 0, 0, 0,  4'b0001, 3'd0, 0, 0);
    step("push_0001",    4'b0010, 4'b1111, 1, 0, 0,  4'b0010, 3'd1, 0, 0);
    step("push_0010",    4'b0100, 4'b1111, 1, 0, 0,  4'b0100, 3'd2, 0, 0);
    step("push_0100",    4'b1000, 4'b1111, 1, 0, 0,  4'b1000, 3'd3, 0, 0);
    step("push_1000",    4'b0000, 4'b0000, 1, 0, 0,  4'b1000, 3'd4, 0, 0);
    step("push_full",    4'b0011, 4'b0011, 1, 0, 0,  4'b1011, 3'd4, 1, 0);
    step("pop_1000",     4'b1111, 4'b1111, 0, 1, 0,  4'b1000, 3'd3, 1, 0);
    step("pop_0100",     4'b1111, 4'b1111, 0, 1, 0,  4'b0100, 3'd2, 1, 0);
    step("pop_0010",     4'b1111, 4'b1111, 0, 1, 0,  4'b0010, 3'd1, 1, 0);
    step("pop_0001",     4'b1111, 4'b1111, 0, 1, 0,  4'b0001, 3'd0, 1, 0);
    step("clear_ovf",    4'b0000, 4'b0000, 0, 0, 1,  4'b0001, 3'd0, 0, 0);

    step("underflow",    4'b0110, 4'b1111, 0, 1, 0,  4'b0110, 3'd0, 0, 1);
    step("clear_unf",    4'b0000, 4'b0000, 0, 0, 1,  4'b0110, 3'd0, 0, 0);
    step("unf_set_wins", 4'b0000, 4'b0000, 0, 1, 1,  4'b0110, 3'd0, 0, 1);
    step("clear_unf2",   4'b0000, 4'b0000, 0, 0, 1,  4'b0110, 3'd0, 0, 0);
    step("save_restore", 4'b1001, 4'b1001, 1, 1, 0,  4'b1111, 3'd0, 0, 0);

    step("set_1100",     4'b1100, 4'b1111, 0, 0, 0,  4'b1100, 3'd0, 0, 0);
    step("fill_1",       4'b0000, 4'b0000, 1, 0, 0,  4'b1100, 3'd1, 0, 0);
    step("fill_2",       4'b0000, 4'b0000, 1, 0, 0,  4'b1100, 3'd2, 0, 0);
    step("fill_3",       4'b0000, 4'b0000, 1, 0, 0,  4'b1100, 3'd3, 0, 0);
    @(negedge clock);
    save = 1'b0;
    drain();

    // Asynchronous reset between edges must clear state without waiting for a clock.
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", observed(), 9'b0000_000_0_0);
    @(negedge clock);
    reset = 1'b1;
    step("post_rst_pop", 4'b0000, 4'b0000, 0, 1, 0,  4'b0000, 3'd0, 0, 1);
    @(negedge clock);
    restore = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no completion, want completion before 20000");
    $fatal(1, "timeout");
  end

endmodule
